// File: rtl/csr_trap_ctrl_if.sv
// rtl/csr_trap_ctrl_if.sv - signal bundle between the pipeline/CSR file and the trap sequencer
interface csr_trap_ctrl_if;
    logic        irq_i;
    logic        global_int_en_i;
    logic        ecall_i;
    logic        ebreak_i;
    logic        mret_i;
    logic [31:0] inst_addr_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic [31:0] mstatus_i;
    logic        ex_csr_we_i;
    logic [31:0] ex_csr_waddr_i;
    logic [31:0] ex_csr_wdata_i;
    logic        csr_we_o;
    logic [31:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        hold_o;
    logic        int_jump_o;
    logic [31:0] int_addr_o;

    // Pipeline / CSR-file side: drives the requests, observes the write port and redirect.
    modport master (
        output irq_i, global_int_en_i, ecall_i, ebreak_i, mret_i,
        output inst_addr_i, jump_flag_i, jump_addr_i,
        output mtvec_i, mepc_i, mstatus_i,
        output ex_csr_we_i, ex_csr_waddr_i, ex_csr_wdata_i,
        input  csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_jump_o, int_addr_o
    );

    // Trap sequencer side.
    modport slave (
        input  irq_i, global_int_en_i, ecall_i, ebreak_i, mret_i,
        input  inst_addr_i, jump_flag_i, jump_addr_i,
        input  mtvec_i, mepc_i, mstatus_i,
        input  ex_csr_we_i, ex_csr_waddr_i, ex_csr_wdata_i,
        output csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_jump_o, int_addr_o
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - machine-mode trap/mret sequencer owning the CSR write port
module csr_trap_ctrl #(
    parameter logic [31:0] IRQ_CAUSE    = 32'h8000000B,
    parameter logic [31:0] ECALL_CAUSE  = 32'd11,
    parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
    input  logic             clk,
    input  logic             rst,
    csr_trap_ctrl_if.slave   bus
);
    localparam logic [31:0] ADDR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] ADDR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] ADDR_MCAUSE  = 32'h0000_0342;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_MEPC, S_WR_MCAUSE, S_WR_MSTATUS, S_MRET_MSTATUS, S_JUMP
    } state_t;

    typedef enum logic [1:0] {
        TT_NONE = 2'd0, TT_TRAP = 2'd1, TT_MRET = 2'd2
    } trap_t;

    state_t      state_q, state_d;
    trap_t       type_q, type_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] int_addr_q, int_addr_d;

    logic        ev_ecall, ev_ebreak, ev_mret, ev_irq, ev_any;
    logic [31:0] jump_target;
    logic [31:0] mstatus_trap;
    logic [31:0] mstatus_mret;

    // Fixed-priority event decode: ecall > ebreak > mret > enabled interrupt.
    always_comb begin
        ev_ecall  = bus.ecall_i;
        ev_ebreak = !bus.ecall_i && bus.ebreak_i;
        ev_mret   = !bus.ecall_i && !bus.ebreak_i && bus.mret_i;
        ev_irq    = !bus.ecall_i && !bus.ebreak_i && !bus.mret_i
                    && bus.irq_i && bus.global_int_en_i;
        ev_any    = ev_ecall || ev_ebreak || ev_mret || ev_irq;
    end

    // Live mstatus rewrites: trap saves MIE into MPIE and clears MIE; mret restores MIE and sets MPIE.
    always_comb begin
        mstatus_trap    = bus.mstatus_i;
        mstatus_trap[7] = bus.mstatus_i[3];
        mstatus_trap[3] = 1'b0;
        mstatus_mret    = bus.mstatus_i;
        mstatus_mret[3] = bus.mstatus_i[7];
        mstatus_mret[7] = 1'b1;
        jump_target     = (type_q == TT_MRET) ? bus.mepc_i : bus.mtvec_i;
    end

    // State and trap-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            type_q     <= TT_NONE;
            cause_q    <= 32'd0;
            pc_q       <= 32'd0;
            int_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            cause_q    <= cause_d;
            pc_q       <= pc_d;
            int_addr_q <= int_addr_d;
        end
    end

    // Next-state and context capture; requests outside IDLE are ignored because the pipeline is held.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        cause_d    = cause_q;
        pc_d       = pc_q;
        int_addr_d = int_addr_q;
        case (state_q)
            S_IDLE: begin
                if (ev_any) begin
                    if (ev_mret) begin
                        type_d  = TT_MRET;
                        state_d = S_MRET_MSTATUS;
                    end else begin
                        type_d  = TT_TRAP;
                        state_d = S_WR_MEPC;
                        if (ev_ecall) begin
                            cause_d = ECALL_CAUSE;
                            pc_d    = bus.inst_addr_i;
                        end else if (ev_ebreak) begin
                            cause_d = EBREAK_CAUSE;
                            pc_d    = bus.inst_addr_i;
                        end else begin
                            // The interrupted instruction's EX write commits, so resume after it.
                            cause_d = IRQ_CAUSE;
                            pc_d    = bus.jump_flag_i ? bus.jump_addr_i
                                                      : bus.inst_addr_i + 32'd4;
                        end
                    end
                end
            end
            S_WR_MEPC:      state_d = S_WR_MCAUSE;
            S_WR_MCAUSE:    state_d = S_WR_MSTATUS;
            S_WR_MSTATUS:   state_d = S_JUMP;
            S_MRET_MSTATUS: state_d = S_JUMP;
            S_JUMP: begin
                int_addr_d = jump_target;
                state_d    = S_IDLE;
            end
            default:        state_d = S_IDLE;
        endcase
    end

    // Output decode: pass the EX write port through in IDLE, otherwise issue the sequenced writes.
    always_comb begin
        bus.csr_we_o    = 1'b0;
        bus.csr_waddr_o = 32'd0;
        bus.csr_wdata_o = 32'd0;
        bus.hold_o      = 1'b1;
        bus.int_jump_o  = 1'b0;
        bus.int_addr_o  = int_addr_q;
        case (state_q)
            S_IDLE: begin
                bus.hold_o      = ev_any;
                bus.csr_we_o    = bus.ex_csr_we_i;
                bus.csr_waddr_o = bus.ex_csr_waddr_i & 32'h0000_0FFF;
                bus.csr_wdata_o = bus.ex_csr_wdata_i;
            end
            S_WR_MEPC: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = ADDR_MEPC;
                bus.csr_wdata_o = pc_q;
            end
            S_WR_MCAUSE: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = ADDR_MCAUSE;
                bus.csr_wdata_o = cause_q;
            end
            S_WR_MSTATUS: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = ADDR_MSTATUS;
                bus.csr_wdata_o = mstatus_trap;
            end
            S_MRET_MSTATUS: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = ADDR_MSTATUS;
                bus.csr_wdata_o = mstatus_mret;
            end
            S_JUMP: begin
                bus.int_jump_o = 1'b1;
                bus.int_addr_o = jump_target;
            end
            default: begin
                bus.hold_o = 1'b1;
            end
        endcase
    end
endmodule
